wb_regfile_unit: RTL and testbench
==================================

WB_REGFILE_UNIT -- requirements
Module: wb_regfile_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32: datapath width.
REQ-002 SHALL have parameter ADDR_W, default 5: register index width.
REQ-003 Clk  input  1  single clock; all state updates on posedge.
REQ-004 Reset_n  input  1  reset, asynchronous, active-low.
REQ-005 MemToRegIn, RegWriteIn, HiSrcIn, LoSrcIn, LinkIn  input  1 each  MEM/WB control outputs.
REQ-006 HiWriteIn, LoWriteIn  input  1 each  Hi/Lo write enables from MEM/WB.
REQ-007 LoadDataIn, ALUResultIn, PC4In  input  DATA_W each  MEM/WB data outputs.
REQ-008 ALU64ResultIn  input  2*DATA_W  64-bit multiply/divide result.
REQ-009 RegDstIn  input  ADDR_W  destination register index.
REQ-010 ReadReg1, ReadReg2  input  ADDR_W each  decode-stage read indices.
REQ-011 ReadData1, ReadData2  output  DATA_W each  decode-stage read data.
REQ-012 HiOut, LoOut  output  DATA_W each  current Hi/Lo values, bypassed.
REQ-013 FwdValid  output  1; FwdReg  output  ADDR_W; FwdData  output  DATA_W  WB forwarding tap.
REQ-014 RetireCount  output  32  count of cycles that committed any architectural write.

Function
REQ-015 WriteData SHALL be PC4In when LinkIn=1, else LoadDataIn when MemToRegIn=1, else ALUResultIn (Link has priority).
REQ-016 On posedge with RegWriteIn=1 and RegDstIn!=0, register[RegDstIn] SHALL take WriteData; writes to register 0 SHALL be discarded.
REQ-017 ReadDataN SHALL be 0 when ReadRegN=0, else WriteData when RegWriteIn=1 and RegDstIn=ReadRegN (write-through bypass), else register[ReadRegN]; purely combinational.
REQ-018 Hi next value SHALL be ALUResultIn when HiSrcIn=1, else ALU64ResultIn[63:32]; Lo next SHALL be ALUResultIn when LoSrcIn=1, else ALU64ResultIn[31:0].
REQ-019 Hi SHALL update on posedge only when HiWriteIn=1; Lo likewise with LoWriteIn; independent of each other.
REQ-020 HiOut/LoOut SHALL show the pending next value when the corresponding write enable is 1, else the stored value.
REQ-021 FwdValid SHALL equal RegWriteIn AND (RegDstIn!=0); FwdReg=RegDstIn; FwdData=WriteData; all combinational.
REQ-022 RetireCount SHALL increment by 1 on each posedge where FwdValid OR HiWriteIn OR LoWriteIn; simultaneous reg+Hi+Lo write counts once.
REQ-023 RetireCount SHALL wrap 0xFFFFFFFF -> 0 without flag.
REQ-024 Write latency SHALL be one cycle to stored state, zero cycles to read/forward outputs via bypass.

Reset
REQ-025 Reset_n=0 SHALL asynchronously clear all 32 registers, Hi, Lo and RetireCount to 0.
REQ-026 Writes presented in the reset-release cycle SHALL be ignored if Reset_n is low at the posedge.
REQ-027 Reset asserted mid-operation SHALL discard any pending write; combinational outputs follow inputs per REQ-017/020/021 with stored state as 0.

Structure
REQ-028 Shared package SHALL hold NUM_REGS=32, REG_ZERO=0, REG_RA=31, DATA_W, ADDR_W.
REQ-029 Register array and bypassed read ports SHALL be a sub-module regfile_32x32; Hi/Lo, write mux, forwarding and counter stay in the top.

Verification
REQ-030 RegWrite=1, RegDst=8, MemToReg=0, ALUResult=0x0000_1234, ReadReg1=8 -> ReadData1=0x1234 same cycle and after posedge; RetireCount=1.
REQ-031 RegWrite=1, RegDst=0, ALUResult=0xDEAD_BEEF -> ReadData(0)=0, FwdValid=0, RetireCount unchanged.
REQ-032 Link=1, MemToReg=1, PC4=0x0040_0008, LoadData=0x5, RegDst=31 -> register 31=0x0040_0008.
REQ-033 HiWrite=LoWrite=1, HiSrc=LoSrc=0, ALU64Result=0x0000_0001_FFFF_FFFE -> Hi=0x1, Lo=0xFFFF_FFFE; then LoWrite=1, LoSrc=1, ALUResult=0x7 -> Lo=0x7, Hi unchanged.
REQ-034 Preload RetireCount to 0xFFFF_FFFF (force), one write cycle -> RetireCount=0.
REQ-035 Write reg 5=0xA5, assert Reset_n=0 between edges -> reg 5, Hi, Lo, RetireCount read 0 immediately.

Source files
------------

// File: rtl/wb_regfile_unit_pkg.sv
// Shared constants and helpers for the write-back / register-file unit.
package wb_regfile_unit_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 31;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;

  // Source of the value written back into the register file
  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'd0,
    WB_SRC_LOAD = 2'd1,
    WB_SRC_LINK = 2'd2
  } wbSrcE;

  // Link beats MemToReg, which beats the ALU result
  function automatic wbSrcE selectWbSrc(input logic link, input logic memToReg);
    if (link)          return WB_SRC_LINK;
    else if (memToReg) return WB_SRC_LOAD;
    else               return WB_SRC_ALU;
  endfunction

endpackage

// File: rtl/wb_regfile_unit_if.sv
// MEM/WB bus into the write-back unit plus its decode-side read and forwarding outputs.
interface wb_regfile_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic                  MemToRegIn;
  logic                  RegWriteIn;
  logic                  HiSrcIn;
  logic                  LoSrcIn;
  logic                  LinkIn;
  logic                  HiWriteIn;
  logic                  LoWriteIn;
  logic [DATA_W-1:0]     LoadDataIn;
  logic [DATA_W-1:0]     ALUResultIn;
  logic [DATA_W-1:0]     PC4In;
  logic [2*DATA_W-1:0]   ALU64ResultIn;
  logic [ADDR_W-1:0]     RegDstIn;
  logic [ADDR_W-1:0]     ReadReg1;
  logic [ADDR_W-1:0]     ReadReg2;
  logic [DATA_W-1:0]     ReadData1;
  logic [DATA_W-1:0]     ReadData2;
  logic [DATA_W-1:0]     HiOut;
  logic [DATA_W-1:0]     LoOut;
  logic                  FwdValid;
  logic [ADDR_W-1:0]     FwdReg;
  logic [DATA_W-1:0]     FwdData;
  logic [31:0]           RetireCount;

  modport master (
    output MemToRegIn, RegWriteIn, HiSrcIn, LoSrcIn, LinkIn, HiWriteIn, LoWriteIn,
    output LoadDataIn, ALUResultIn, PC4In, ALU64ResultIn, RegDstIn, ReadReg1, ReadReg2,
    input  ReadData1, ReadData2, HiOut, LoOut, FwdValid, FwdReg, FwdData, RetireCount
  );

  modport slave (
    input  MemToRegIn, RegWriteIn, HiSrcIn, LoSrcIn, LinkIn, HiWriteIn, LoWriteIn,
    input  LoadDataIn, ALUResultIn, PC4In, ALU64ResultIn, RegDstIn, ReadReg1, ReadReg2,
    output ReadData1, ReadData2, HiOut, LoOut, FwdValid, FwdReg, FwdData, RetireCount
  );

endinterface

// File: rtl/wb_regfile_unit_regfile_32x32.sv
// 32-entry register array with two write-through read ports; register 0 reads as zero.
module regfile_32x32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              WriteEnable,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);
  import wb_regfile_unit_pkg::*;

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Store the write-back value; the caller already masks writes to register 0
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (WriteEnable) begin
      regs[WriteAddr] <= WriteData;
    end
  end

  // Read ports: zero register, then same-cycle bypass of the pending write, then storage
  always_comb begin
    ReadData1 = regs[ReadReg1];
    ReadData2 = regs[ReadReg2];
    if (ReadReg1 == ADDR_W'(REG_ZERO))                  ReadData1 = '0;
    else if (WriteEnable && (WriteAddr == ReadReg1))    ReadData1 = WriteData;
    if (ReadReg2 == ADDR_W'(REG_ZERO))                  ReadData2 = '0;
    else if (WriteEnable && (WriteAddr == ReadReg2))    ReadData2 = WriteData;
  end

endmodule

// File: rtl/wb_regfile_unit.sv
// Write-back stage: result mux, register file, Hi/Lo pair, forwarding tap and retire counter.
module wb_regfile_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic              Clk,
  input logic              Reset_n,
  wb_regfile_unit_if.slave wb
);
  import wb_regfile_unit_pkg::*;

  wbSrcE             wbSrc;
  logic [DATA_W-1:0] writeData;
  logic              regWriteEn;
  logic [DATA_W-1:0] hiNext;
  logic [DATA_W-1:0] loNext;
  logic [DATA_W-1:0] hiReg;
  logic [DATA_W-1:0] loReg;
  logic [31:0]       retireCount;
  logic              retireEvent;

  // Pick the write-back value and the next Hi/Lo candidates
  always_comb begin
    wbSrc     = selectWbSrc(wb.LinkIn, wb.MemToRegIn);
    writeData = wb.ALUResultIn;
    case (wbSrc)
      WB_SRC_LINK: writeData = wb.PC4In;
      WB_SRC_LOAD: writeData = wb.LoadDataIn;
      default:     writeData = wb.ALUResultIn;
    endcase
    hiNext      = wb.HiSrcIn ? wb.ALUResultIn : wb.ALU64ResultIn[2*DATA_W-1:DATA_W];
    loNext      = wb.LoSrcIn ? wb.ALUResultIn : wb.ALU64ResultIn[DATA_W-1:0];
    regWriteEn  = wb.RegWriteIn && (wb.RegDstIn != ADDR_W'(REG_ZERO));
    retireEvent = regWriteEn || wb.HiWriteIn || wb.LoWriteIn;
  end

  regfile_32x32 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) uRegfile (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .WriteEnable(regWriteEn),
    .WriteAddr  (wb.RegDstIn),
    .WriteData  (writeData),
    .ReadReg1   (wb.ReadReg1),
    .ReadReg2   (wb.ReadReg2),
    .ReadData1  (wb.ReadData1),
    .ReadData2  (wb.ReadData2)
  );

  // Hi and Lo update independently under their own enables
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hiReg <= '0;
      loReg <= '0;
    end else begin
      if (wb.HiWriteIn) hiReg <= hiNext;
      if (wb.LoWriteIn) loReg <= loNext;
    end
  end

  // One count per cycle that commits anything; wraps silently
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)         retireCount <= '0;
    else if (retireEvent) retireCount <= retireCount + 32'd1;
  end

  // Bypassed Hi/Lo view and the forwarding tap
  always_comb begin
    wb.HiOut       = wb.HiWriteIn ? hiNext : hiReg;
    wb.LoOut       = wb.LoWriteIn ? loNext : loReg;
    wb.FwdValid    = regWriteEn;
    wb.FwdReg      = wb.RegDstIn;
    wb.FwdData     = writeData;
    wb.RetireCount = retireCount;
  end

endmodule

// File: tb/tb_wb_regfile_unit.sv
// Scoreboard bench for wb_regfile_unit against an independent reference model.
module tb_wb_regfile_unit;
  import wb_regfile_unit_pkg::*;

  typedef struct {
    logic        memToReg, regWrite, hiSrc, loSrc, link, hiWrite, loWrite;
    logic [31:0] load, alu, pc4;
    logic [63:0] alu64;
    logic [4:0]  dst, rr1, rr2;
  } txn_t;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t expQ[$];

  logic [31:0] refRegs [32];
  logic [31:0] refHi, refLo, refCount;

  always #5 Clk = ~Clk;

  wb_regfile_unit_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_regfile_unit #(.DATA_W(32), .ADDR_W(5)) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .wb     (bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    expQ.push_back(e);
  endtask

  task automatic popCheck(input logic [63:0] obs);
    exp_t e;
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_underflow", obs, ~obs);
    end else begin
      e = expQ.pop_front();
      checkOutput(e.tag, obs, e.val);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 32; i++) refRegs[i] = 32'h0;
    refHi = 32'h0;
    refLo = 32'h0;
    refCount = 32'h0;
  endfunction

  function automatic logic [31:0] modelWd(input txn_t t);
    if (t.link)     return t.pc4;
    if (t.memToReg) return t.load;
    return t.alu;
  endfunction

  function automatic logic [31:0] modelRead(input txn_t t, input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (t.regWrite && t.dst == r) return modelWd(t);
    return refRegs[r];
  endfunction

  function automatic txn_t idleTxn(input logic [4:0] rr1, input logic [4:0] rr2);
    txn_t t;
    t = '{default: '0};
    t.rr1 = rr1;
    t.rr2 = rr2;
    return t;
  endfunction

  task automatic applyStimulus(input txn_t t);
    bus.MemToRegIn    = t.memToReg;
    bus.RegWriteIn    = t.regWrite;
    bus.HiSrcIn       = t.hiSrc;
    bus.LoSrcIn       = t.loSrc;
    bus.LinkIn        = t.link;
    bus.HiWriteIn     = t.hiWrite;
    bus.LoWriteIn     = t.loWrite;
    bus.LoadDataIn    = t.load;
    bus.ALUResultIn   = t.alu;
    bus.PC4In         = t.pc4;
    bus.ALU64ResultIn = t.alu64;
    bus.RegDstIn      = t.dst;
    bus.ReadReg1      = t.rr1;
    bus.ReadReg2      = t.rr2;
  endtask

  // Drive one transaction, check combinational outputs, clock it, update the model
  task automatic runCycle(input txn_t t);
    logic [31:0] wd, hiN, loN;
    logic        fv;
    applyStimulus(t);
    wd  = modelWd(t);
    hiN = t.hiSrc ? t.alu : t.alu64[63:32];
    loN = t.loSrc ? t.alu : t.alu64[31:0];
    fv  = t.regWrite && (t.dst != 5'd0);
    pushExp("readData1", 64'(modelRead(t, t.rr1)));
    pushExp("readData2", 64'(modelRead(t, t.rr2)));
    pushExp("hiOut", 64'(t.hiWrite ? hiN : refHi));
    pushExp("loOut", 64'(t.loWrite ? loN : refLo));
    pushExp("fwdValid", 64'(fv));
    pushExp("fwdReg", 64'(t.dst));
    pushExp("fwdData", 64'(wd));
    pushExp("retireCount", 64'(refCount));
    #1;
    popCheck(64'(bus.ReadData1));
    popCheck(64'(bus.ReadData2));
    popCheck(64'(bus.HiOut));
    popCheck(64'(bus.LoOut));
    popCheck(64'(bus.FwdValid));
    popCheck(64'(bus.FwdReg));
    popCheck(64'(bus.FwdData));
    popCheck(64'(bus.RetireCount));
    @(posedge Clk);
    if (Reset_n) begin
      if (fv) refRegs[t.dst] = wd;
      if (t.hiWrite) refHi = hiN;
      if (t.loWrite) refLo = loN;
      if (fv || t.hiWrite || t.loWrite) refCount = refCount + 32'd1;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    txn_t t;
    modelReset();
    applyStimulus(idleTxn(5'd8, 5'd31));
    repeat (2) @(posedge Clk);
    #1;
    runCycle(idleTxn(5'd8, 5'd31));
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // Plain ALU write to r8: bypassed same cycle, stored afterwards
    t = idleTxn(5'd8, 5'd0);
    t.regWrite = 1'b1; t.dst = 5'd8; t.alu = 32'h0000_1234;
    runCycle(t);
    runCycle(idleTxn(5'd8, 5'd8));

    // Write to r0 is dropped and not retired
    t = idleTxn(5'd0, 5'd8);
    t.regWrite = 1'b1; t.dst = 5'd0; t.alu = 32'hDEAD_BEEF;
    runCycle(t);
    runCycle(idleTxn(5'd0, 5'd8));

    // Link beats MemToReg into the return-address register
    t = idleTxn(5'd1, 5'(REG_RA));
    t.regWrite = 1'b1; t.link = 1'b1; t.memToReg = 1'b1;
    t.pc4 = 32'h0040_0008; t.load = 32'h5; t.alu = 32'h99; t.dst = 5'(REG_RA);
    runCycle(t);
    runCycle(idleTxn(5'(REG_RA), 5'd8));

    // Load path when not linking
    t = idleTxn(5'd3, 5'd0);
    t.regWrite = 1'b1; t.memToReg = 1'b1; t.load = 32'hCAFE_0001; t.alu = 32'h1; t.dst = 5'd3;
    runCycle(t);

    // Hi/Lo from the 64-bit result, then Lo alone from the ALU
    t = idleTxn(5'd0, 5'd0);
    t.hiWrite = 1'b1; t.loWrite = 1'b1; t.alu64 = 64'h0000_0001_FFFF_FFFE;
    runCycle(t);
    t = idleTxn(5'd0, 5'd0);
    t.loWrite = 1'b1; t.loSrc = 1'b1; t.alu = 32'h7; t.alu64 = 64'hAAAA_AAAA_BBBB_BBBB;
    runCycle(t);
    runCycle(idleTxn(5'd3, 5'd31));

    // Randomised mix of everything
    for (int i = 0; i < 40; i++) begin
      t.memToReg = 1'($urandom); t.regWrite = 1'($urandom); t.hiSrc = 1'($urandom);
      t.loSrc = 1'($urandom); t.link = 1'($urandom); t.hiWrite = 1'($urandom);
      t.loWrite = 1'($urandom);
      t.load = $urandom; t.alu = $urandom; t.pc4 = $urandom;
      t.alu64 = {$urandom, $urandom};
      t.dst = 5'($urandom_range(0, 7));
      t.rr1 = 5'($urandom_range(0, 7));
      t.rr2 = 5'($urandom_range(0, 31));
      runCycle(t);
    end

    // Counter wrap from all-ones
    force dut.retireCount = 32'hFFFF_FFFF;
    #1;
    release dut.retireCount;
    refCount = 32'hFFFF_FFFF;
    t = idleTxn(5'd9, 5'd0);
    t.regWrite = 1'b1; t.dst = 5'd9; t.alu = 32'h0000_0909;
    runCycle(t);
    runCycle(idleTxn(5'd9, 5'd0));

    // Reset between edges clears state immediately; writes under reset are ignored
    t = idleTxn(5'd5, 5'd0);
    t.regWrite = 1'b1; t.dst = 5'd5; t.alu = 32'h0000_00A5;
    t.hiWrite = 1'b1; t.loWrite = 1'b1; t.alu64 = 64'h1111_2222_3333_4444;
    runCycle(t);
    Reset_n = 1'b0;
    modelReset();
    t = idleTxn(5'd5, 5'd6);
    t.regWrite = 1'b1; t.dst = 5'd6; t.alu = 32'h0000_0066;
    runCycle(t);
    applyStimulus(idleTxn(5'd5, 5'd6));
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    runCycle(idleTxn(5'd5, 5'd6));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
